// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_decoder
// Description : Receives a multiplexed active-low 7-segment bus and rebuilds
//               one hex word per complete scan frame.
// Revision    : 1.0 - initial release
// ============================================================================

module seg7_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_n,
    input  logic [DIGITS-1:0]     dig_n,
    output logic [4*DIGITS-1:0]   value,
    output logic                  valid,
    output logic                  err
);

    localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_PRE = CNT_W'(STABLE_CYCLES - 2);

    logic [6:0]                 seg_q,       seg_d;
    logic [DIGITS-1:0]          dig_q,       dig_d;
    logic [CNT_W-1:0]           cnt_q,       cnt_d;
    logic                       cap_q,       cap_d;
    logic [DIGITS-1:0][3:0]     shadow_q,    shadow_d;
    logic [DIGITS-1:0]          seen_q,      seen_d;
    logic                       frame_err_q, frame_err_d;
    logic [4*DIGITS-1:0]        value_q,     value_d;
    logic                       valid_q,     valid_d;
    logic                       err_q,       err_d;

    logic                       w_change;
    logic [6:0]                 w_lc;
    logic [3:0]                 w_nib;
    logic                       w_code_ok;
    logic [DIGITS-1:0]          w_sel;
    logic                       w_onehot;
    logic [IDX_W-1:0]           w_idx;
    logic                       w_frame_end;

    always_comb begin
        w_nib     = 4'h0;
        w_code_ok = 1'b1;
        w_lc      = ~seg_q;
        case (w_lc)
            7'h3F:   w_nib = 4'h0;
            7'h06:   w_nib = 4'h1;
            7'h5B:   w_nib = 4'h2;
            7'h4F:   w_nib = 4'h3;
            7'h66:   w_nib = 4'h4;
            7'h6D:   w_nib = 4'h5;
            7'h7D:   w_nib = 4'h6;
            7'h07:   w_nib = 4'h7;
            7'h7F:   w_nib = 4'h8;
            7'h6F:   w_nib = 4'h9;
            7'h77:   w_nib = 4'hA;
            7'h7C:   w_nib = 4'hB;
            7'h39:   w_nib = 4'hC;
            7'h5E:   w_nib = 4'hD;
            7'h79:   w_nib = 4'hE;
            7'h71:   w_nib = 4'hF;
            default: w_code_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_sel    = ~dig_q;
        w_onehot = (w_sel != '0) && ((w_sel & (w_sel - 1'b1)) == '0);
        w_idx    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_sel[i]) begin
                w_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        seg_d    = seg_n;
        dig_d    = dig_n;
        w_change = ({seg_n, dig_n} != {seg_q, dig_q});
        cnt_d    = cnt_q;
        if (w_change) begin
            cnt_d = '0;
        end else if (cnt_q != c_CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
        // Strobe is registered so the shadow write lands one edge after the count saturates.
        cap_d = !w_change && (cnt_q == c_CNT_PRE);
    end

    always_comb begin
        w_frame_end = &seen_q;
        shadow_d    = shadow_q;
        seen_d      = w_frame_end ? '0 : seen_q;
        frame_err_d = w_frame_end ? 1'b0 : frame_err_q;
        // A capture coinciding with frame end belongs to the next frame.
        if (cap_q) begin
            if (w_onehot) begin
                shadow_d[w_idx] = w_nib;
                seen_d[w_idx]   = 1'b1;
                if (!w_code_ok) begin
                    frame_err_d = 1'b1;
                end
            end else begin
                frame_err_d = 1'b1;
            end
        end
        value_d = value_q;
        err_d   = err_q;
        valid_d = 1'b0;
        if (w_frame_end) begin
            value_d = shadow_q;
            err_d   = frame_err_q;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q       <= 7'h7F;
            dig_q       <= '1;
            cnt_q       <= '0;
            cap_q       <= 1'b0;
            shadow_q    <= '0;
            seen_q      <= '0;
            frame_err_q <= 1'b0;
            value_q     <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            seg_q       <= seg_d;
            dig_q       <= dig_d;
            cnt_q       <= cnt_d;
            cap_q       <= cap_d;
            shadow_q    <= shadow_d;
            seen_q      <= seen_d;
            frame_err_q <= frame_err_d;
            value_q     <= value_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    assign value = value_q;
    assign valid = valid_q;
    assign err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_decoder
// Description : Directed bench with a frame scoreboard for seg7_scan_decoder.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_seg7_scan_decoder;

    localparam int DIGITS = 4;
    localparam int STABLE = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg_n = 7'h7F;
    logic [3:0]  dig_n = 4'hF;
    logic [15:0] value;
    logic        valid;
    logic        err;

    seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .seg_n (seg_n),
        .dig_n (dig_n),
        .value (value),
        .valid (valid),
        .err   (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] value;
        logic        err;
        int          at_edge;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [10:0] cur = 11'h7FF;
    int          run_start = 0;
    bit          captured = 1'b0;
    logic [3:0]  m_shadow [4];
    logic [3:0]  m_seen = 4'h0;
    logic        m_ferr = 1'b0;
    logic [15:0] last_value = 16'h0;
    logic        last_err = 1'b0;
    logic        prev_valid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] dsel(input int i);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << i);
    endfunction

    function automatic void decode(input logic [6:0] lc, output logic [3:0] nib, output logic ok);
        ok = 1'b1;
        case (lc)
            7'h3F: nib = 4'h0;  7'h06: nib = 4'h1;  7'h5B: nib = 4'h2;  7'h4F: nib = 4'h3;
            7'h66: nib = 4'h4;  7'h6D: nib = 4'h5;  7'h7D: nib = 4'h6;  7'h07: nib = 4'h7;
            7'h7F: nib = 4'h8;  7'h6F: nib = 4'h9;  7'h77: nib = 4'hA;  7'h7C: nib = 4'hB;
            7'h39: nib = 4'hC;  7'h5E: nib = 4'hD;  7'h79: nib = 4'hE;  7'h71: nib = 4'hF;
            default: begin nib = 4'h0; ok = 1'b0; end
        endcase
    endfunction

    function automatic void model_capture(input logic [6:0] s, input logic [3:0] d, input int cap_edge);
        int   lows;
        int   idx;
        logic [3:0] nib;
        logic ok;
        exp_t e;
        lows = 0;
        idx  = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!d[i]) begin lows++; idx = i; end
        end
        if (lows == 1) begin
            decode(~s, nib, ok);
            m_shadow[idx] = nib;
            m_seen[idx]   = 1'b1;
            if (!ok) m_ferr = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
        if (m_seen == 4'hF) begin
            e.value   = {m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]};
            e.err     = m_ferr;
            e.at_edge = cap_edge + 1;
            sb_q.push_back(e);
            m_seen = 4'h0;
            m_ferr = 1'b0;
        end
    endfunction

    // Called #1 after an edge; holds {s,d} on the bus for n edges.
    task automatic step(input logic [6:0] s, input logic [3:0] d, input int n);
        int c;
        c     = cyc;
        seg_n = s;
        dig_n = d;
        if ({s, d} != cur) begin
            cur       = {s, d};
            run_start = c + 1;
            captured  = 1'b0;
        end
        if (!captured && (c + n >= run_start + STABLE - 1)) begin
            captured = 1'b1;
            model_capture(s, d, run_start + STABLE);
        end
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n      = 1'b0;
        last_value = 16'h0;
        last_err   = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        cur       = 11'h7FF;
        run_start = cyc;
        captured  = 1'b0;
        m_seen    = 4'h0;
        m_ferr    = 1'b0;
        for (int i = 0; i < DIGITS; i++) m_shadow[i] = 4'h0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (valid) begin
                chk("valid_expected", 32'(sb_q.size() != 0), 1);
                chk("valid_single", 32'(prev_valid), 0);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("frame_value", 32'(value), 32'(e.value));
                    chk("frame_err", 32'(err), 32'(e.err));
                    chk("frame_edge", cyc, e.at_edge);
                    last_value = e.value;
                    last_err   = e.err;
                end
            end else begin
                chk("value_hold", 32'(value), 32'(last_value));
                chk("err_hold", 32'(err), 32'(last_err));
            end
        end
        prev_valid = valid;
    end

    initial begin
        @(posedge clk);
        #1;

        // Reset state, then an idle bus must not produce a frame.
        do_reset(2);
        chk("reset_value", 32'(value), 0);
        chk("reset_valid", 32'(valid), 0);
        chk("reset_err", 32'(err), 0);
        step(7'h7F, 4'hF, 20);

        // Clean scan starting straight out of reset: 4321.
        seg_n = 7'h79;
        dig_n = dsel(0);
        do_reset(2);
        step(7'h79, dsel(0), 6);
        step(7'h24, dsel(1), 6);
        step(7'h30, dsel(2), 6);
        step(7'h19, dsel(3), 6);

        // Short glitch inside the digit 1 hold is ignored: 4320.
        step(7'h40, dsel(0), 6);
        step(7'h24, dsel(1), 2);
        step(7'h12, dsel(1), 3);
        step(7'h24, dsel(1), 6);
        step(7'h30, dsel(2), 6);
        step(7'h19, dsel(3), 6);

        // Blank digit flags the frame: 8065 err, then a clean 3210.
        step(7'h12, dsel(0), 6);
        step(7'h02, dsel(1), 6);
        step(7'h7F, dsel(2), 6);
        step(7'h00, dsel(3), 6);
        step(7'h40, dsel(0), 6);
        step(7'h79, dsel(1), 6);
        step(7'h24, dsel(2), 6);
        step(7'h30, dsel(3), 6);

        // Two digits selected at once, then a clean scan: BA98 err.
        step(7'h78, 4'b1100, 10);
        step(7'h00, dsel(0), 6);
        step(7'h10, dsel(1), 6);
        step(7'h08, dsel(2), 6);
        step(7'h03, dsel(3), 6);

        // Long hold on digit 3 must capture once, else the next frame ends early.
        step(7'h46, dsel(0), 6);
        step(7'h21, dsel(1), 6);
        step(7'h06, dsel(2), 6);
        step(7'h0E, dsel(3), 100);
        step(7'h40, dsel(0), 6);
        step(7'h79, dsel(1), 6);
        step(7'h24, dsel(2), 6);
        step(7'h30, dsel(3), 6);

        // Reset mid-frame discards digits 0,1.
        step(7'h79, dsel(0), 6);
        step(7'h24, dsel(1), 6);
        do_reset(1);
        step(7'h30, dsel(2), 6);
        step(7'h19, dsel(3), 6);
        step(7'h79, dsel(0), 6);
        step(7'h24, dsel(1), 6);
        step(7'h30, dsel(2), 6);
        step(7'h19, dsel(3), 6);

        repeat (10) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
